axil_reg8_responder: RTL

AXI4-Lite responder exposing eight 32-bit read/write control registers as parallel output ports. It is the slave-side end of the AXI4-Lite link the PS/VIP master drives: it accepts single-beat writes and reads at offsets 0x00–0x1C and returns OKAY/SLVERR responses. It sits between the AXI interconnect and the fabric logic that consumes the eight register values.

---
 rtl/axil_reg8_pkg.sv | 47 ++++
 rtl/axil_reg8_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axil_reg8_pkg.sv
// axil_reg8_pkg
//   Shared constants and helpers for the eight-register AXI4-Lite responder:
//   register count and width, AXI response codes, byte offsets of each
//   register, the held write-beat record and the byte-strobe merge.
package axil_reg8_pkg;

  localparam int NUM_REGS   = 8;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte offsets of the register window (ADDR[4:2] selects the register).
  localparam logic [4:0] REG0_OFF = 5'h00;
  localparam logic [4:0] REG1_OFF = 5'h04;
  localparam logic [4:0] REG2_OFF = 5'h08;
  localparam logic [4:0] REG3_OFF = 5'h0C;
  localparam logic [4:0] REG4_OFF = 5'h10;
  localparam logic [4:0] REG5_OFF = 5'h14;
  localparam logic [4:0] REG6_OFF = 5'h18;
  localparam logic [4:0] REG7_OFF = 5'h1C;

  // Write-data beat held until its address partner arrives.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
  } wbeat_t;

  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regfile_t;

  // Byte i of the result comes from wdata when strb[i] is set, else from cur.
  function automatic logic [DATA_WIDTH-1:0] strb_merge(
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = cur;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_reg8_responder.sv
// axil_reg8_responder
//   AXI4-Lite slave exposing eight 32-bit read/write registers as parallel
//   outputs. AW and W beats are captured independently into holding
//   registers; a write commits one cycle after both are held, provided the
//   B channel is free (or being drained at that same edge). Reads answer
//   directly from the register file one cycle after the AR handshake.
//
//   Parameters: ADDR_WIDTH (>=5, bits above [4] must be zero for a valid
//               access), RESET_VAL (reset value of every register).
//   Ports:      ACLK, ARESET (async, active-high)
//               AW*/W*/B*  write address / data / response channels
//               AR*/R*     read address / data channels
//               reg_out    current register values, reg_out[k] = register k
//               wr_pulse   one-cycle strobe per register on a valid commit,
//                          present only when AXIL_REG8_WPULSE_EN is defined
module axil_reg8_responder
  import axil_reg8_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                                ACLK,
  input  logic                                ARESET,
  input  logic [ADDR_WIDTH-1:0]               AWADDR,
  input  logic [2:0]                          AWPROT,
  input  logic                                AWVALID,
  output logic                                AWREADY,
  input  logic [DATA_WIDTH-1:0]               WDATA,
  input  logic [STRB_WIDTH-1:0]               WSTRB,
  input  logic                                WVALID,
  output logic                                WREADY,
  output logic [1:0]                          BRESP,
  output logic                                BVALID,
  input  logic                                BREADY,
  input  logic [ADDR_WIDTH-1:0]               ARADDR,
  input  logic [2:0]                          ARPROT,
  input  logic                                ARVALID,
  output logic                                ARREADY,
  output logic [DATA_WIDTH-1:0]               RDATA,
  output logic [1:0]                          RRESP,
  output logic                                RVALID,
  input  logic                                RREADY,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_out
`ifdef AXIL_REG8_WPULSE_EN
  ,
  output logic [NUM_REGS-1:0]                 wr_pulse
`endif
);

  // Only bits [4:2] select a register; anything set above bit 4 is outside
  // the window. The shift form also covers ADDR_WIDTH == 5.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >> 5) == '0;
  endfunction

  logic             aw_held_q, w_held_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic             aw_ok_q;
  wbeat_t           w_q;
  logic             bvalid_q, rvalid_q;
  logic [1:0]       bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  regfile_t         regs_q, regs_d;

  logic aw_hs, w_hs, ar_hs, commit;

  // Readies are forced low for as long as reset is asserted, not just
  // from the next edge, so nothing can handshake during reset.
  assign AWREADY = ~aw_held_q & ~ARESET;
  assign WREADY  = ~w_held_q  & ~ARESET;
  assign ARREADY = ~rvalid_q  & ~ARESET;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID  & WREADY;
  assign ar_hs = ARVALID & ARREADY;

  // A commit may overlap the B handshake of the previous response.
  assign commit = aw_held_q & w_held_q & (~bvalid_q | BREADY);

  always_comb begin
    regs_d = regs_q;
    if (commit && aw_ok_q)
      regs_d[aw_idx_q] = strb_merge(regs_q[aw_idx_q], w_q.data, w_q.strb);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      w_held_q  <= 1'b0;
      w_q       <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      regs_q    <= {NUM_REGS{RESET_VAL}};
    end else begin
      // AWREADY/WREADY are low while held, so capture and commit never
      // coincide on the same channel.
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= AWADDR[4:2];
        aw_ok_q   <= addr_ok(AWADDR);
      end else if (commit) begin
        aw_held_q <= 1'b0;
      end

      if (w_hs) begin
        w_held_q <= 1'b1;
        w_q      <= '{data: WDATA, strb: WSTRB};
      end else if (commit) begin
        w_held_q <= 1'b0;
      end

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && BREADY) begin
        bvalid_q <= 1'b0;
      end

      regs_q <= regs_d;

      // Read samples regs_q, so a same-edge commit is not yet visible.
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= addr_ok(ARADDR) ? RESP_OKAY : RESP_SLVERR;
        rdata_q  <= addr_ok(ARADDR) ? regs_q[ARADDR[4:2]] : '0;
      end else if (rvalid_q && RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef AXIL_REG8_WPULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit && aw_ok_q) wr_pulse_q[aw_idx_q] <= 1'b1;
    end
  end

  assign wr_pulse = wr_pulse_q;
`endif

  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign reg_out = regs_q;

  // Protection bits and the byte lane within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

endmodule
